// File: rtl/bpu_pkg.sv
// Shared BTB geometry, update-queue entry layout and update FSM states.
package bpu_pkg;

    localparam int BTB_IDX_W = 9;
    localparam int BTB_SLOTS = 4;
    localparam int BTB_TGT_W = 32;
    localparam int BTB_SET_W = BTB_SLOTS * BTB_TGT_W;
    localparam int SLOT_W    = 2;

    localparam int PC_IDX_LSB  = 4;
    localparam int PC_IDX_MSB  = PC_IDX_LSB + BTB_IDX_W - 1;
    localparam int PC_SLOT_LSB = 2;
    localparam int PC_SLOT_MSB = PC_SLOT_LSB + SLOT_W - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WRITE,
        ST_SKIP
    } upd_state_e;

    // Only the pc bits that select set and slot are worth queueing.
    typedef struct packed {
        logic [BTB_IDX_W-1:0] idx;
        logic [SLOT_W-1:0]    slot;
        logic [BTB_TGT_W-1:0] target;
    } upd_entry_t;

    localparam int UPD_ENTRY_W = $bits(upd_entry_t);

    function automatic upd_entry_t make_entry(input logic [31:0] pc, input logic [31:0] target);
        upd_entry_t e;
        e.idx    = pc[PC_IDX_MSB:PC_IDX_LSB];
        e.slot   = pc[PC_SLOT_MSB:PC_SLOT_LSB];
        e.target = target;
        return e;
    endfunction

endpackage

// File: rtl/bpu_fifo.sv
// Small synchronous FIFO with first-word-fall-through head and full/empty flags.
module bpu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/btb_update_ctrl.sv
// Queues resolved taken-branch updates and applies each as a read-modify-write of one
// BTB set, sharing the BTB port with fetch lookups under a starvation guard.
module btb_update_ctrl
    import bpu_pkg::*;
#(
    parameter int QDEPTH       = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [31:0]          upd_pc,
    input  logic [31:0]          upd_target,
    input  logic                 fetch_req,
    input  logic [BTB_IDX_W-1:0] fetch_raddr,
    output logic                 fetch_stall,
    output logic                 btb_ce,
    output logic                 btb_we,
    output logic [BTB_IDX_W-1:0] btb_raddr,
    output logic [BTB_IDX_W-1:0] btb_waddr,
    output logic                 btb_wvalid,
    output logic [BTB_SET_W-1:0] btb_wtargets,
    input  logic                 btb_rvalid,
    input  logic [BTB_SET_W-1:0] btb_rtargets,
    output logic [31:0]          upd_done_count,
    output logic [31:0]          upd_skip_count
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    upd_state_e           state_q, state_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic [BTB_SET_W-1:0] merged_q, merged_d;
    logic [31:0]          done_q, done_d;
    logic [31:0]          skip_q, skip_d;

    upd_entry_t           push_entry;
    upd_entry_t           head;
    logic                 q_full;
    logic                 q_empty;
    logic                 q_pop;
    logic                 grant;
    logic                 already_present;
    logic [BTB_SET_W-1:0] base_set;
    logic [BTB_SET_W-1:0] merged_set;
    logic [BTB_SLOTS-1:0] slot_match;
    logic                 unused_pc_bits;

    assign push_entry     = make_entry(upd_pc, upd_target);
    assign unused_pc_bits = ^{upd_pc[31:PC_IDX_MSB+1], upd_pc[PC_SLOT_LSB-1:0]};
    assign upd_ready      = !q_full;

    bpu_fifo #(
        .WIDTH (UPD_ENTRY_W),
        .DEPTH (QDEPTH)
    ) u_upd_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (upd_valid),
        .push_data_i (push_entry),
        .pop_i       (q_pop),
        .head_o      (head),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    // Missing sets merge into an all-zero base so stale SRAM data never leaks in.
    assign base_set = btb_rvalid ? btb_rtargets : '0;

    for (genvar gi = 0; gi < BTB_SLOTS; gi++) begin : g_slot
        logic this_slot;
        assign this_slot = (head.slot == SLOT_W'(gi));
        assign merged_set[gi*BTB_TGT_W +: BTB_TGT_W] =
            this_slot ? head.target : base_set[gi*BTB_TGT_W +: BTB_TGT_W];
        assign slot_match[gi] =
            this_slot && (base_set[gi*BTB_TGT_W +: BTB_TGT_W] == head.target);
    end

    assign already_present = btb_rvalid && (|slot_match);
    assign grant           = !fetch_req || (starve_q == STARVE_MAX);

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        merged_d     = merged_q;
        done_d       = done_q;
        skip_d       = skip_q;
        q_pop        = 1'b0;
        btb_ce       = fetch_req;
        btb_we       = 1'b0;
        btb_raddr    = fetch_raddr;
        btb_waddr    = '0;
        btb_wvalid   = 1'b0;
        btb_wtargets = '0;
        fetch_stall  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_d = ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                if (grant) begin
                    btb_ce      = 1'b1;
                    btb_raddr   = head.idx;
                    fetch_stall = fetch_req;
                    state_d     = ST_RD_WAIT;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            ST_RD_WAIT: begin
                merged_d = merged_set;
                state_d  = already_present ? ST_SKIP : ST_WRITE;
            end
            ST_WRITE: begin
                if (grant) begin
                    btb_ce       = 1'b1;
                    btb_we       = 1'b1;
                    btb_raddr    = '0;
                    btb_waddr    = head.idx;
                    btb_wvalid   = 1'b1;
                    btb_wtargets = merged_q;
                    fetch_stall  = fetch_req;
                    done_d       = done_q + 32'd1;
                    q_pop        = 1'b1;
                    starve_d     = '0;
                    state_d      = ST_IDLE;
                end else if (starve_q != STARVE_MAX) begin
                    starve_d = starve_q + 1'b1;
                end
            end
            ST_SKIP: begin
                skip_d   = skip_q + 32'd1;
                q_pop    = 1'b1;
                starve_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            merged_q <= '0;
            done_q   <= '0;
            skip_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            merged_q <= merged_d;
            done_q   <= done_d;
            skip_q   <= skip_d;
        end
    end

    assign upd_done_count = done_q;
    assign upd_skip_count = skip_q;

endmodule
